// File: rtl/fuzzy_cut_sched.sv
// Round-robin scheduler that shares one combinational cut-line unit among NREQ requesters.
// Each operation takes a fixed two cycles from acceptance to response.
module fuzzy_cut_sched #(
   parameter int unsigned LongBits_limit = 10,
   parameter int unsigned NREQ           = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NREQ-1:0]                  req_valid,
   output logic [NREQ-1:0]                  req_ready,
   input  logic [NREQ*LongBits_limit-1:0]   req_cut_line,
   input  logic [NREQ*LongBits_limit-1:0]   req_x,
   input  logic [NREQ*LongBits_limit-1:0]   req_y,
   output logic [NREQ-1:0]                  rsp_valid,
   input  logic [NREQ-1:0]                  rsp_ready,
   output logic [LongBits_limit-1:0]        rsp_z,
   output logic [LongBits_limit-1:0]        cu_cut_line,
   output logic [LongBits_limit-1:0]        cu_x,
   output logic [LongBits_limit-1:0]        cu_y,
   input  logic [LongBits_limit-1:0]        cu_z,
   output logic                             busy,
   output logic [15:0]                      op_count
);

   localparam int unsigned W    = LongBits_limit;
   localparam int unsigned PtrW = $clog2(NREQ);

   typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

   state_e          state_q, state_d;
   logic [PtrW-1:0] ptr_q, ptr_d;
   logic [PtrW-1:0] owner_q, owner_d;
   logic [W-1:0]    cu_cut_line_q, cu_cut_line_d;
   logic [W-1:0]    cu_x_q, cu_x_d;
   logic [W-1:0]    cu_y_q, cu_y_d;
   logic [W-1:0]    rsp_z_q, rsp_z_d;
   logic [15:0]     op_count_q, op_count_d;

   logic [PtrW-1:0] winner;
   logic            win_found;
   int unsigned     cand;

   // First valid requester at or after ptr, wrapping around.
   always_comb begin
      winner    = '0;
      win_found = 1'b0;
      cand      = 0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         cand = 32'(ptr_q) + i;
         if (cand >= NREQ) begin
            cand = cand - NREQ;
         end
         if (!win_found && req_valid[cand[PtrW-1:0]]) begin
            win_found = 1'b1;
            winner    = cand[PtrW-1:0];
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      owner_d       = owner_q;
      cu_cut_line_d = cu_cut_line_q;
      cu_x_d        = cu_x_q;
      cu_y_d        = cu_y_q;
      rsp_z_d       = rsp_z_q;
      op_count_d    = op_count_q;
      req_ready     = '0;
      rsp_valid     = '0;
      unique case (state_q)
         StIdle: begin
            if (win_found) begin
               req_ready[winner] = 1'b1;
               owner_d           = winner;
               cu_cut_line_d     = req_cut_line[32'(winner)*W +: W];
               cu_x_d            = req_x[32'(winner)*W +: W];
               cu_y_d            = req_y[32'(winner)*W +: W];
               ptr_d             = (32'(winner) + 1 >= NREQ) ? '0 : winner + PtrW'(1);
               state_d           = StIssue;
            end
         end
         StIssue: begin
            rsp_z_d = cu_z;
            state_d = StResp;
         end
         StResp: begin
            rsp_valid[owner_q] = 1'b1;
            if (rsp_ready[owner_q]) begin
               state_d = StIdle;
               if (op_count_q != 16'hFFFF) begin
                  op_count_d = op_count_q + 16'd1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
      // Nothing may be accepted on a reset edge.
      if (rst) begin
         req_ready = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StIdle;
         ptr_q         <= '0;
         owner_q       <= '0;
         cu_cut_line_q <= '0;
         cu_x_q        <= '0;
         cu_y_q        <= '0;
         rsp_z_q       <= '0;
         op_count_q    <= '0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         owner_q       <= owner_d;
         cu_cut_line_q <= cu_cut_line_d;
         cu_x_q        <= cu_x_d;
         cu_y_q        <= cu_y_d;
         rsp_z_q       <= rsp_z_d;
         op_count_q    <= op_count_d;
      end
   end

   assign cu_cut_line = cu_cut_line_q;
   assign cu_x        = cu_x_q;
   assign cu_y        = cu_y_q;
   assign rsp_z       = rsp_z_q;
   assign op_count    = op_count_q;
   assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_fuzzy_cut_sched.sv
// Self-checking bench for fuzzy_cut_sched: a transaction-level model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_fuzzy_cut_sched;

   localparam int W = 10;
   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
   logic [N*W-1:0] req_cut_line, req_x, req_y;
   logic [W-1:0]   rsp_z, cu_cut_line, cu_x, cu_y, cu_z;
   logic           busy;
   logic [15:0]    op_count;

   assign cu_z = cu_x | cu_y;

   fuzzy_cut_sched #(.LongBits_limit(W), .NREQ(N)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_cut_line (req_cut_line),
      .req_x        (req_x),
      .req_y        (req_y),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_z        (rsp_z),
      .cu_cut_line  (cu_cut_line),
      .cu_x         (cu_x),
      .cu_y         (cu_y),
      .cu_z         (cu_z),
      .busy         (busy),
      .op_count     (op_count)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cycle   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   function automatic int pick(input logic [N-1:0] v, input int p);
      for (int i = 0; i < N; i++) begin
         if (v[(p + i) % N]) return (p + i) % N;
      end
      return -1;
   endfunction

   // Transaction-level model: one operation in flight at most, aged by cycles since acceptance.
   bit           m_on = 1'b0;
   bit           m_busy;
   int           m_age, m_owner, m_ptr, m_count, mk;
   logic [W-1:0] m_cc, m_cx, m_cy, m_z;
   logic [N-1:0] e_rr, e_rv;
   int           preload_seq = 0;
   int           preload_val = 0;
   int           m_pre_seen  = 0;
   int           g_idx[$];
   int           g_cyc[$];

   initial begin
      forever begin
         @(negedge clk);
         cycle++;
         if (preload_seq != m_pre_seen) begin
            m_count    = preload_val;
            m_pre_seen = preload_seq;
         end
         if (m_on) begin
            e_rr = '0;
            if (!m_busy && !rst) begin
               mk = pick(req_valid, m_ptr);
               if (mk >= 0) e_rr[mk] = 1'b1;
            end
            e_rv = '0;
            if (m_busy && m_age >= 2) e_rv[m_owner] = 1'b1;
            chk("req_ready", req_ready, e_rr);
            chk("rsp_valid", rsp_valid, e_rv);
            chk("busy", busy, m_busy);
            chk("rsp_z", rsp_z, m_z);
            chk("cu_x", cu_x, m_cx);
            chk("cu_y", cu_y, m_cy);
            chk("cu_cut_line", cu_cut_line, m_cc);
            chk("op_count", op_count, m_count);
            for (int i = 0; i < N; i++) begin
               if (req_ready[i]) begin
                  g_idx.push_back(i);
                  g_cyc.push_back(cycle);
               end
            end
         end
         if (rst) begin
            m_on = 1'b1; m_busy = 1'b0; m_ptr = 0; m_owner = 0; m_age = 0;
            m_cc = '0; m_cx = '0; m_cy = '0; m_z = '0; m_count = 0;
         end else if (m_on) begin
            if (!m_busy) begin
               mk = pick(req_valid, m_ptr);
               if (mk >= 0) begin
                  m_busy = 1'b1; m_age = 1; m_owner = mk;
                  m_cc = req_cut_line[mk*W +: W];
                  m_cx = req_x[mk*W +: W];
                  m_cy = req_y[mk*W +: W];
                  m_ptr = (mk + 1) % N;
               end
            end else if (m_age == 1) begin
               m_z   = m_cx | m_cy;
               m_age = 2;
            end else if (rsp_ready[m_owner]) begin
               m_busy = 1'b0;
               if (m_count < 65535) m_count++;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   task automatic set_req(input int k, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] c);
      req_x[k*W +: W]        = x;
      req_y[k*W +: W]        = y;
      req_cut_line[k*W +: W] = c;
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish, %0d cycles elapsed", cycle);
      $fatal(1);
   end

   int gstart;
   int exp_order[5];

   initial begin
      exp_order = '{0, 1, 2, 3, 0};
      rst = 1'b1; req_valid = '0; rsp_ready = '0;
      req_x = '0; req_y = '0; req_cut_line = '0;
      repeat (3) step();
      at_neg();
      chk("reset_busy", busy, 0);
      chk("reset_op_count", op_count, 0);
      chk("reset_rsp_valid", rsp_valid, 0);
      chk("reset_req_ready", req_ready, 0);
      step(); rst = 1'b0;

      // Single request from requester 2.
      step(); set_req(2, 10'h0F0, 10'h00F, 10'h3FF); req_valid = 4'b0100; rsp_ready = 4'b1111;
      at_neg(); chk("single_ready_T", req_ready, 4'b0100);
      step(); req_valid = '0;
      at_neg(); chk("single_valid_T1", rsp_valid, 0); chk("single_cu_x", cu_x, 10'h0F0);
      step();
      at_neg(); chk("single_valid_T2", rsp_valid, 4'b0100); chk("single_rsp_z", rsp_z, 10'h0FF);
      step();
      at_neg(); chk("single_op_count", op_count, 1); chk("single_idle", busy, 0);

      // Owner 3 with only rsp_ready[0] high: no handshake.
      step(); set_req(3, 10'h201, 10'h010, 10'h155); req_valid = 4'b1000; rsp_ready = 4'b0001;
      at_neg(); chk("wo_ready", req_ready, 4'b1000);
      step(); req_valid = '0;
      step();
      repeat (4) begin
         at_neg(); chk("wo_rsp_valid", rsp_valid, 4'b1000); chk("wo_rsp_z", rsp_z, 10'h211);
         step();
      end
      rsp_ready = 4'b1000;
      step();
      at_neg(); chk("wo_done_count", op_count, 2); chk("wo_done_busy", busy, 0);

      // Backpressure on requester 1 while everyone else keeps requesting.
      step(); set_req(1, 10'h155, 10'h2A0, 10'h0AA); req_valid = 4'b0010; rsp_ready = 4'b1101;
      at_neg(); chk("bp_ready", req_ready, 4'b0010);
      step();
      set_req(0, 10'h001, 10'h002, 10'h003);
      set_req(2, 10'h040, 10'h004, 10'h3C0);
      set_req(3, 10'h300, 10'h00C, 10'h111);
      req_valid = 4'b1111;
      step();
      repeat (5) begin
         at_neg();
         chk("bp_rsp_valid", rsp_valid, 4'b0010);
         chk("bp_rsp_z", rsp_z, 10'h3F5);
         chk("bp_no_ready", req_ready, 0);
         step();
      end
      rsp_ready = 4'b1111;
      at_neg(); chk("bp_last_valid", rsp_valid, 4'b0010);
      step();
      at_neg(); chk("bp_done_count", op_count, 3); chk("bp_next_grant", req_ready, 4'b0100);

      // Reset while requester 2 is in ISSUE.
      step(); rst = 1'b1;
      at_neg(); chk("rst_issue_busy", busy, 1);
      step(); rst = 1'b0;
      gstart = g_idx.size();
      at_neg();
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_rsp_valid", rsp_valid, 0);
      chk("rst_mid_cu_x", cu_x, 0);
      chk("rst_mid_op_count", op_count, 0);
      chk("rst_mid_winner", req_ready, 4'b0001);

      // All four valid with rsp_ready high: strict rotation, one grant per three cycles.
      repeat (13) step();
      chk("rr_grants", g_idx.size() - gstart, 5);
      if (g_idx.size() - gstart >= 5) begin
         for (int i = 0; i < 5; i++) begin
            chk("rr_order", g_idx[gstart + i], exp_order[i]);
            if (i > 0) chk("rr_spacing", g_cyc[gstart + i] - g_cyc[gstart + i - 1], 3);
         end
      end
      req_valid = '0;
      repeat (4) step();
      at_neg(); chk("rr_op_count", op_count, 5);

      // Saturation: preload near the top, then four more completions.
      step();
      force dut.op_count_q = 16'hFFFD;
      preload_val = 16'hFFFD;
      preload_seq++;
      step(); step();
      release dut.op_count_q;
      req_valid = 4'b0001;
      repeat (12) step();
      req_valid = '0;
      repeat (4) step();
      at_neg(); chk("sat_op_count", op_count, 16'hFFFF);

      step();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fuzzy_cut_sched.md
FUZZY_CUT_SCHED -- requirements
Module: fuzzy_cut_sched

Interface
REQ-001 Parameter LongBits_limit, default 10: operand and result width in bits.
REQ-002 Parameter NREQ, default 4: number of requesters sharing the cut-line unit; legal range 2..8.
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port req_valid, input, NREQ: per-requester operation request.
REQ-006 Port req_ready, output, NREQ: per-requester accept strobe; at most one bit high in any cycle.
REQ-007 Port req_cut_line, input, NREQ*LongBits_limit: cut-line control word; requester k occupies slice [k*W +: W].
REQ-008 Port req_x, input, NREQ*LongBits_limit: X operands, same slicing.
REQ-009 Port req_y, input, NREQ*LongBits_limit: Y operands, same slicing.
REQ-010 Port rsp_valid, output, NREQ: result valid for the owning requester; at most one bit high.
REQ-011 Port rsp_ready, input, NREQ: per-requester result accept.
REQ-012 Port rsp_z, output, LongBits_limit: result word, shared by all requesters.
REQ-013 Ports cu_cut_line, cu_x, cu_y, output, LongBits_limit each: registered operands to the shared combinational cut-line unit.
REQ-014 Port cu_z, input, LongBits_limit: combinational result from the shared unit.
REQ-015 Port busy, output, 1: high whenever the state is not IDLE.
REQ-016 Port op_count, output, 16: count of completed operations; saturates at 0xFFFF.

Function
REQ-017 The FSM SHALL have the states IDLE, ISSUE and RESP, encoded as an enumerated type.
REQ-018 In IDLE with any req_valid bit high, the block SHALL pick the winner k by round-robin starting at the priority pointer ptr, assert req_ready[k] combinationally in that cycle, and register slice k into the cu_* outputs and owner=k.
REQ-019 Acceptance SHALL update ptr to (k+1) mod NREQ and move the FSM to ISSUE.
REQ-020 In ISSUE, the block SHALL drive the registered cu_* outputs, capture cu_z into rsp_z at the end of the cycle, and move to RESP.
REQ-021 In RESP, rsp_valid[owner] SHALL be high and rsp_z stable until rsp_ready[owner] is high; the FSM SHALL then return to IDLE and increment op_count.
REQ-022 Latency SHALL be fixed: acceptance in cycle T gives rsp_valid in cycle T+2.
REQ-023 The next acceptance SHALL occur no earlier than the cycle after the response handshake.
REQ-024 req_ready SHALL be all zeros outside IDLE.
REQ-025 req_valid may change while not accepted; the arbiter SHALL use only current-cycle values.
REQ-026 rsp_ready bits other than rsp_ready[owner] SHALL be ignored.
REQ-027 cu_* outputs SHALL hold their last value outside ISSUE.
REQ-028 op_count SHALL stay at 0xFFFF once reached.

Reset
REQ-029 When rst is high at a clock edge, the block SHALL set state=IDLE, ptr=0, owner=0, cu_*=0, rsp_z=0, op_count=0, and force rsp_valid, req_ready and busy to 0; this takes priority over all other events, including reset during ISSUE or RESP, and the in-flight operation is dropped with no response.

Verification (bench models cu_z = cu_x | cu_y)
REQ-030 Single request: rst released, req_valid=4'b0100, x=0x0F0, y=0x00F, cut=0x3FF -> req_ready[2] in T, rsp_valid[2] in T+2 with rsp_z=0x0FF, op_count=1 after the handshake.
REQ-031 All four requesters held valid continuously with rsp_ready=all ones -> grant order 0,1,2,3,0; one grant every 3 cycles; req_ready is never multi-hot.
REQ-032 Backpressure: rsp_ready[1] held low for 5 cycles during RESP -> rsp_valid[1] and rsp_z stay stable, no new req_ready; completes on the cycle rsp_ready[1]=1.
REQ-033 Reset mid-operation: rst asserted during ISSUE -> next cycle busy=0, rsp_valid=0, cu_x=0, op_count unchanged at 0 (fresh), ptr=0 so requester 0 wins the next contest of all four.
REQ-034 Saturation: force 65536 completions (or preload via a test hook) -> op_count stays 0xFFFF on further completions.
REQ-035 Wrong-owner accept: owner=3, rsp_ready=4'b0001 -> no handshake; rsp_valid[3] stays high.
